// File: rtl/edge_zone_counter_if.sv
// Pixel stream in, per-zone edge counts and hit flags out.
interface edge_zone_counter_if #(
    parameter int NZ = 12
);
    logic          pixel_valid;
    logic [9:0]    x_pixel;
    logic [9:0]    y_pixel;
    logic          edge_in;
    logic [14:0]   thresh;
    logic [3:0]    rd_sel;
    logic [14:0]   rd_count;
    logic [NZ-1:0] hit;
    logic          frame_done;

    modport master (
        output pixel_valid, x_pixel, y_pixel, edge_in, thresh, rd_sel,
        input  rd_count, hit, frame_done
    );

    modport slave (
        input  pixel_valid, x_pixel, y_pixel, edge_in, thresh, rd_sel,
        output rd_count, hit, frame_done
    );
endinterface

// File: rtl/edge_zone_counter.sv
// Counts Sobel edge pixels per screen zone over one SOF..EOF frame
// and publishes latched counts and threshold hits at end of frame.
module edge_zone_counter #(
    parameter int H_RES  = 640,
    parameter int V_RES  = 480,
    parameter int CELL_W = 160,
    parameter int CELL_H = 160
) (
    input  logic               clk,
    input  logic               reset,
    edge_zone_counter_if.slave bus
);
    localparam int NCOL = H_RES / CELL_W;
    localparam int NROW = V_RES / CELL_H;
    localparam int NZ   = NCOL * NROW;
    localparam logic [14:0] SAT = 15'h7FFF;

    typedef struct packed {
        logic       valid;
        logic [3:0] zone;
        logic       edg;
        logic       sof;
        logic       eof;
    } pix_t;

    typedef enum logic [1:0] {
        WAIT_SOF,
        ACCUM,
        LATCH
    } state_t;

    pix_t          in_pix;
    pix_t          s1;
    pix_t          sk;
    logic          sk_full;
    logic          stall;
    state_t        state;
    state_t        state_nx;
    logic          clr;
    logic          inc;
    logic          latch;
    logic [NZ-1:0] bump;
    logic [14:0]   cnt [NZ];
    logic [14:0]   lat [NZ];
    logic [NZ-1:0] hit_q;
    logic          fd_q;
    logic [14:0]   rd_q;

    always_comb begin : decode
        int x;
        int y;
        int col;
        int row;
        x   = int'(bus.x_pixel);
        y   = int'(bus.y_pixel);
        col = 0;
        row = 0;
        for (int c = 1; c < NCOL; c++)
            if (x >= c * CELL_W) col = c;
        for (int r = 1; r < NROW; r++)
            if (y >= r * CELL_H) row = r;
        in_pix       = '0;
        in_pix.valid = bus.pixel_valid && (x < H_RES) && (y < V_RES);
        in_pix.zone  = 4'(row * NCOL + col);
        in_pix.edg   = bus.edge_in;
        in_pix.sof   = in_pix.valid && (x == 0) && (y == 0);
        in_pix.eof   = in_pix.valid && (x == H_RES - 1) && (y == V_RES - 1);
    end

    // A SOF sitting in stage 1 during LATCH is held; the pixel arriving
    // meanwhile parks in a one-entry skid that drains on the next idle cycle.
    assign stall = (state == LATCH) && s1.valid && s1.sof;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1      <= '0;
            sk      <= '0;
            sk_full <= 1'b0;
        end else if (stall) begin
            if (!sk_full) begin
                sk      <= in_pix;
                sk_full <= in_pix.valid;
            end
        end else if (sk_full) begin
            s1      <= sk;
            sk      <= in_pix;
            sk_full <= in_pix.valid;
        end else begin
            s1 <= in_pix;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= WAIT_SOF;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        clr      = 1'b0;
        inc      = 1'b0;
        latch    = 1'b0;
        unique case (state)
            WAIT_SOF: begin
                if (s1.valid && s1.sof) begin
                    state_nx = ACCUM;
                    clr      = 1'b1;
                    inc      = s1.edg;
                end
            end
            ACCUM: begin
                if (s1.valid) begin
                    clr = s1.sof;
                    inc = s1.edg;
                    if (s1.eof) state_nx = LATCH;
                end
            end
            LATCH: begin
                latch    = 1'b1;
                state_nx = WAIT_SOF;
            end
            default: state_nx = WAIT_SOF;
        endcase
    end

    always_comb begin
        bump = '0;
        for (int i = 0; i < NZ; i++)
            bump[i] = inc && (s1.zone == 4'(i));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NZ; i++) cnt[i] <= '0;
        end else begin
            for (int i = 0; i < NZ; i++) begin
                if (clr)
                    cnt[i] <= bump[i] ? 15'd1 : 15'd0;
                else if (bump[i] && cnt[i] != SAT)
                    cnt[i] <= cnt[i] + 15'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NZ; i++) lat[i] <= '0;
            hit_q <= '0;
            fd_q  <= 1'b0;
        end else begin
            fd_q <= latch;
            if (latch) begin
                for (int i = 0; i < NZ; i++) begin
                    lat[i]   <= cnt[i];
                    hit_q[i] <= cnt[i] >= bus.thresh;
                end
            end
        end
    end

    always_comb begin
        rd_q = '0;
        for (int i = 0; i < NZ; i++)
            if (bus.rd_sel == 4'(i)) rd_q = lat[i];
    end

    assign bus.rd_count   = rd_q;
    assign bus.hit        = hit_q;
    assign bus.frame_done = fd_q;
endmodule

// File: tb/tb_edge_zone_counter.sv
// Randomized frame bench for edge_zone_counter with a zone-count model.
module tb_edge_zone_counter;
    localparam int H  = 64;
    localparam int V  = 48;
    localparam int CW = 16;
    localparam int CH = 16;
    localparam int NC = H / CW;
    localparam int NZ = 12;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    edge_zone_counter_if #(.NZ(NZ)) bus ();

    edge_zone_counter #(
        .H_RES (H),
        .V_RES (V),
        .CELL_W(CW),
        .CELL_H(CH)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int counts[NZ];
    int exp_lat[NZ];
    int exp_hit = 0;
    bit acc = 1'b0;
    int fd_exp[$];
    int density = 50;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (fd_exp.size() > 0 && fd_exp[0] < cyc) begin
            check("fd_missing", cyc, fd_exp[0]);
            void'(fd_exp.pop_front());
        end
        if (bus.frame_done) begin
            if (fd_exp.size() > 0) begin
                check("fd_time", cyc, fd_exp[0]);
                void'(fd_exp.pop_front());
            end else begin
                check("fd_unexpected", 1, 0);
            end
        end
    end

    task automatic model_pixel(input bit v, input int x, input int y, input bit e);
        if (!v || x >= H || y >= V) return;
        if (x == 0 && y == 0) begin
            acc = 1'b1;
            foreach (counts[i]) counts[i] = 0;
        end
        if (!acc) return;
        if (e) counts[(y / CH) * NC + x / CW]++;
        if (x == H - 1 && y == V - 1) begin
            acc = 1'b0;
            exp_hit = 0;
            foreach (counts[i]) begin
                exp_lat[i] = counts[i];
                if (counts[i] >= int'(bus.thresh)) exp_hit |= (1 << i);
            end
            fd_exp.push_back(cyc + 3);
        end
    endtask

    task automatic send(input bit v, input int x, input int y, input bit e);
        @(posedge clk);
        #1;
        bus.pixel_valid = v;
        bus.x_pixel     = 10'(x);
        bus.y_pixel     = 10'(y);
        bus.edge_in     = e;
        model_pixel(v, x, y, e);
    endtask

    task automatic idle(input int n);
        repeat (n) send(1'b0, 0, 0, 1'b0);
    endtask

    function automatic bit pat_edge(input int pat, input int x, input int y);
        case (pat)
            0:       return 1'b0;
            1:       return 1'b1;
            2:       return (x >= 16 && x < 32 && y < 16);
            default: return ($urandom_range(0, 99) < density);
        endcase
    endfunction

    // Blanking between rows, sometimes carrying out-of-range pixels.
    task automatic gap(input int y);
        send(1'b0, 0, 0, 1'b0);
        case ($urandom_range(0, 3))
            1:       send(1'b1, 700, y, 1'b1);
            2:       send(1'b1, $urandom_range(0, H - 1), 500, 1'b1);
            3:       send(1'b1, H, V - 1, 1'b1);
            default: ;
        endcase
    endtask

    task automatic drive_rows(input int pat, input int y0, input int y1);
        for (int y = y0; y < y1; y++) begin
            if (y != y0) gap(y);
            for (int x = 0; x < H; x++) send(1'b1, x, y, pat_edge(pat, x, y));
        end
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        bus.pixel_valid = 1'b0;
        reset = 1'b1;
        acc = 1'b0;
        exp_hit = 0;
        foreach (counts[i]) begin
            counts[i]  = 0;
            exp_lat[i] = 0;
        end
        fd_exp.delete();
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic check_results();
        for (int i = 0; i < NZ; i++) begin
            @(negedge clk);
            bus.rd_sel = 4'(i);
            #1;
            check("rd_count", int'(bus.rd_count), exp_lat[i]);
        end
        @(negedge clk);
        bus.rd_sel = 4'd12;
        #1;
        check("rd_sel12", int'(bus.rd_count), 0);
        bus.rd_sel = 4'd13;
        #1;
        check("rd_sel13", int'(bus.rd_count), 0);
        check("hit", int'(bus.hit), exp_hit);
        check("fd_pending", fd_exp.size(), 0);
    endtask

    initial begin
        foreach (counts[i]) begin
            counts[i]  = 0;
            exp_lat[i] = 0;
        end
        bus.pixel_valid = 1'b0;
        bus.x_pixel     = '0;
        bus.y_pixel     = '0;
        bus.edge_in     = 1'b0;
        bus.thresh      = '0;
        bus.rd_sel      = '0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;

        @(negedge clk);
        check("rst_hit", int'(bus.hit), 0);
        check("rst_fd", int'(bus.frame_done), 0);
        check("rst_rd", int'(bus.rd_count), 0);

        bus.thresh = 15'd256;
        drive_rows(1, 0, V);
        idle(5);
        check_results();

        bus.thresh = 15'd1;
        drive_rows(2, 0, V);
        idle(5);
        check_results();

        drive_rows(1, 0, 20);
        drive_rows(0, 0, V);
        idle(5);
        check_results();

        drive_rows(1, 0, 30);
        do_reset();
        check_results();
        drive_rows(1, 30, V);
        idle(5);
        check_results();
        density = 50;
        bus.thresh = 15'($urandom_range(100, 160));
        drive_rows(3, 0, V);
        idle(5);
        check_results();

        bus.thresh = 15'd100;
        density = $urandom_range(20, 80);
        drive_rows(3, 0, V);
        idle(5);
        check_results();
        drive_rows(3, 0, 24);
        @(negedge clk);
        check("hit_hold", int'(bus.hit), exp_hit);
        bus.thresh = 15'd30000;
        drive_rows(3, 24, 40);
        @(negedge clk);
        check("hit_hold2", int'(bus.hit), exp_hit);
        drive_rows(3, 40, V);
        idle(5);
        check_results();

        bus.thresh = 15'($urandom_range(0, 256));
        density = $urandom_range(0, 100);
        drive_rows(3, 0, V);
        drive_rows(3, 0, V);
        idle(5);
        check_results();

        for (int f = 0; f < 3; f++) begin
            bus.thresh = 15'($urandom_range(0, 256));
            density = $urandom_range(0, 100);
            drive_rows(3, 0, V);
            idle(5);
            check_results();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/edge_zone_counter.md
EDGE_ZONE_COUNTER -- requirements
Module: edge_zone_counter

Interface
REQ-001 The module SHALL have a parameter H_RES, default 640, active pixels per line.
REQ-002 The module SHALL have a parameter V_RES, default 480, active lines per frame.
REQ-003 The module SHALL have a parameter CELL_W, default 160, zone width in pixels.
REQ-004 The module SHALL have a parameter CELL_H, default 160, zone height in pixels; the grid is (H_RES/CELL_W) x (V_RES/CELL_H) = 4x3 = 12 zones, both divisions exact.
REQ-005 The module SHALL have one clock and an asynchronous, active-high reset.
REQ-006 clk  input  1  rising-edge system/pixel clock.
REQ-007 reset  input  1  asynchronous, active-high reset.
REQ-008 pixel_valid  input  1  the x_pixel, y_pixel and edge_in values are valid this cycle.
REQ-009 x_pixel  input  10  column of the current pixel.
REQ-010 y_pixel  input  10  row of the current pixel.
REQ-011 edge_in  input  1  Sobel edge result for the pixel: 1 = edge.
REQ-012 thresh  input  15  minimum edge count for a zone hit.
REQ-013 rd_sel  input  4  zone index selected for count readout.
REQ-014 rd_count  output  15  latched count of zone rd_sel; 0 when rd_sel is 12 or greater.
REQ-015 hit  output  12  hit[i] = 1 when the latched count of zone i is greater than or equal to thresh.
REQ-016 frame_done  output  1  one-cycle pulse when new latched results are available.

Function
REQ-017 The zone index SHALL be (y_pixel/CELL_H)*4 + (x_pixel/CELL_W), derived with comparators, not a divider.
REQ-018 Pipeline: stage 1 SHALL register valid, zone index, edge_in, the SOF flag and the EOF flag; stage 2 SHALL update the counters.
REQ-019 SOF SHALL be defined as pixel_valid with x_pixel=0 and y_pixel=0.
REQ-020 EOF SHALL be defined as pixel_valid with x_pixel=H_RES-1 and y_pixel=V_RES-1.
REQ-021 A pixel with x_pixel of H_RES or more, or y_pixel of V_RES or more, SHALL be ignored and SHALL NOT be counted.
REQ-022 The FSM SHALL have the states WAIT_SOF, ACCUM and LATCH, and SHALL enter WAIT_SOF on reset.
REQ-023 WAIT_SOF -> ACCUM on a stage-1 SOF: all 12 working counters cleared, then that SOF pixel counted.
REQ-024 In ACCUM, each stage-1 valid pixel with edge=1 SHALL increment its zone's working counter by 1.
REQ-025 Working counters SHALL saturate at 0x7FFF and SHALL never wrap.
REQ-026 ACCUM -> LATCH on a stage-1 EOF, after the EOF pixel has been counted.
REQ-027 In LATCH, for one cycle, all working counters SHALL be copied to the latched counters, hit SHALL be recomputed from thresh sampled in that cycle, and frame_done SHALL be 1.
REQ-028 LATCH -> WAIT_SOF unconditionally after one cycle.
REQ-029 frame_done SHALL rise exactly 3 clk cycles after the EOF pixel is presented at the inputs.
REQ-030 A SOF in ACCUM (aborted frame) SHALL clear the working counters and stay in ACCUM, with no latch and no frame_done.
REQ-031 Pixels in WAIT_SOF other than SOF SHALL be ignored.
REQ-032 A SOF arriving in LATCH SHALL be held in the stage-1 register and processed in the following WAIT_SOF cycle, with no pixel lost.
REQ-033 hit and rd_count SHALL hold their values between LATCH cycles; changes to thresh take effect only at the next LATCH.
REQ-034 rd_count SHALL be combinational from rd_sel and the latched counters.

Reset
REQ-035 Reset SHALL force the FSM to WAIT_SOF and clear the working counters, latched counters, pipeline registers, hit (0x000) and frame_done (0).
REQ-036 A reset asserted mid-frame SHALL discard the partial counts; no frame_done SHALL be produced until a complete SOF..EOF frame has been received after reset.

Verification
REQ-037 Full 640x480 frame, edge_in=1 everywhere, thresh=25600 -> every rd_count=25600, hit=0xFFF, frame_done pulses 3 cycles after EOF.
REQ-038 Edge only in x 160..319, y 0..159, thresh=1 -> zone 1 count=25600, other zones 0, hit=0x002.
REQ-039 Frame with SOF re-issued at pixel (0,200) then a clean full frame of zeros -> no frame_done for the aborted frame; second frame gives all counts 0, hit=0x000.
REQ-040 Reset pulsed at row 300 of a frame with all edges set -> hit=0x000, no frame_done until the next full frame.
REQ-041 Coordinates x=700 and y=500 driven with edge=1 -> counts unchanged; rd_sel=13 -> rd_count=0.
REQ-042 thresh changed from 100 to 30000 mid-frame -> hit computed with 30000 at LATCH only; before LATCH, hit still reflects the previous frame's results.
